// File: rtl/ltc2308_sampler.sv
// LTC2308 sampling front end: paces conversions, runs the SPI exchange, publishes results with a strobe.
// Optional macro ADC_OVERSAMPLE_EN averages four consecutive conversions into each published sample.
module ltc2308_sampler #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int SAMPLE_DIV  = 1000,
  parameter int CHANNEL     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int CMAX  = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int TMR_W = $clog2(SAMPLE_DIV);
  localparam logic [2:0]  CH  = 3'(CHANNEL);
  // S/D, O/S, S1, S0, UNI, SLP, then six don't-care zeros
  localparam logic [11:0] CFG = {1'b1, CH[0], CH[2], CH[1], 1'b1, 1'b0, 6'b0};

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic             half_q, half_d;
  logic [11:0]      shreg_q, shreg_d;
  logic             supp_q, supp_d;
  logic             convst_q, convst_d;
  logic             sck_q, sck_d;
  logic             sdi_q, sdi_d;
  logic [11:0]      sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic             tick, done;
`ifdef ADC_OVERSAMPLE_EN
  logic [13:0]      acc_q, acc_d, acc_sum;
  logic [1:0]       ph_q, ph_d;
`endif

  assign tick = (tmr_q == TMR_W'(SAMPLE_DIV - 1));

  always_comb begin
    tmr_d   = tick ? '0 : tmr_q + 1'b1;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    half_d  = half_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: if (tick && enable) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: if (cnt_q == CNT_W'(1)) begin
        state_d = WAIT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      WAIT: if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
        half_d  = 1'b0;
      end else cnt_d = cnt_q + 1'b1;
      SHIFT: begin
        // first cycle of each high phase is the SCK rising edge
        if (half_q && cnt_q == '0) shreg_d = {shreg_q[10:0], adc_sdo};
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d  = '0;
          half_d = ~half_q;
          if (half_q) begin
            if (bit_q == 4'd11) state_d = DONE;
            else bit_d = bit_q + 1'b1;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  assign done = (state_q == SHIFT) && (state_d == DONE);

  always_comb begin
    convst_d = (state_d == START);
    busy_d   = (state_d != IDLE);
    sck_d    = (state_d == SHIFT) && half_d;
    sdi_d    = (state_d == SHIFT) ? CFG[4'd11 - bit_d] : 1'b0;
    ovr_d    = ovr_q | (tick && state_q != IDLE);
    supp_d   = done ? 1'b0 : supp_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
`ifdef ADC_OVERSAMPLE_EN
    acc_sum  = acc_q + {2'b00, shreg_d};
    acc_d    = acc_q;
    ph_d     = ph_q;
    if (done && !supp_q) begin
      if (ph_q == 2'd3) begin
        sample_d = acc_sum[13:2];
        valid_d  = 1'b1;
        acc_d    = '0;
        ph_d     = '0;
      end else begin
        acc_d = acc_sum;
        ph_d  = ph_q + 2'd1;
      end
    end
`else
    if (done && !supp_q) begin
      sample_d = shreg_d;
      valid_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q    <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      half_q   <= 1'b0;
      shreg_q  <= '0;
      supp_q   <= 1'b1;
      convst_q <= 1'b0;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef ADC_OVERSAMPLE_EN
      acc_q    <= '0;
      ph_q     <= '0;
`endif
    end else begin
      tmr_q    <= tmr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      half_q   <= half_d;
      shreg_q  <= shreg_d;
      supp_q   <= supp_d;
      convst_q <= convst_d;
      sck_q    <= sck_d;
      sdi_q    <= sdi_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
`ifdef ADC_OVERSAMPLE_EN
      acc_q    <= acc_d;
      ph_q     <= ph_d;
`endif
    end
  end

  assign adc_convst   = convst_q;
  assign adc_sck      = sck_q;
  assign adc_sdi      = sdi_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_ltc2308_sampler.sv
// Bench for ltc2308_sampler: two instances (CHANNEL=5 defaults, SAMPLE_DIV=100) with behavioural LTC2308 models.
module tb_ltc2308_sampler;
  localparam int TP    = 10;
  localparam int DIV_A = 1000;
  localparam int DIV_B = 100;
  localparam int CONV  = 80;
  localparam int CDIV  = 2;
  localparam int LAT   = 3 + CONV + 24 * CDIV;
  localparam logic [11:0] ADC_B = 12'h6E1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b1, enable_a = 1'b0, adc_sdo_a;
  logic adc_convst_a, adc_sck_a, adc_sdi_a, sample_valid_a, busy_a, overrun_a;
  logic [11:0] sample_a;
  logic reset_b = 1'b1, enable_b = 1'b0, adc_sdo_b;
  logic adc_convst_b, adc_sck_b, adc_sdi_b, sample_valid_b, busy_b, overrun_b;
  logic [11:0] sample_b;

  ltc2308_sampler #(.CHANNEL(5)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .adc_convst(adc_convst_a),
    .adc_sck(adc_sck_a), .adc_sdi(adc_sdi_a), .adc_sdo(adc_sdo_a), .sample(sample_a),
    .sample_valid(sample_valid_a), .busy(busy_a), .overrun(overrun_a));

  ltc2308_sampler #(.SAMPLE_DIV(DIV_B)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .adc_convst(adc_convst_b),
    .adc_sck(adc_sck_b), .adc_sdi(adc_sdi_b), .adc_sdo(adc_sdo_b), .sample(sample_b),
    .sample_valid(sample_valid_b), .busy(busy_b), .overrun(overrun_b));

  // Bench-side sample timers: tick is the cycle where the count equals DIV-1.
  int tmr_a = 0, tmr_b = 0;
  always @(posedge clk) tmr_a <= (reset_a || tmr_a == DIV_A - 1) ? 0 : tmr_a + 1;
  always @(posedge clk) tmr_b <= (reset_b || tmr_b == DIV_B - 1) ? 0 : tmr_b + 1;

  // LTC2308 model A: result MSB out after CONVST falls, next bit on each SCK fall, SDI taken on SCK rise.
  logic [11:0] adc_val_a = '0, sh_a = '0, sdiw_a = '0;
  logic cv_pa = 1'b0, sk_pa = 1'b0;
  int   rises_a = 0, crises_a = 0;
  time  t_cf_a = 0, t_r_a = 0, t_f_a = 0, first_dt_a = 0;
  time  hi_min = 1000000, hi_max = 0, lo_min = 1000000, lo_max = 0;
  assign adc_sdo_a = sh_a[11];
  always @(adc_convst_a or adc_sck_a) begin
    if (cv_pa && !adc_convst_a) begin
      sh_a = adc_val_a; crises_a = 0; t_cf_a = $time;
    end
    if (!sk_pa && adc_sck_a) begin
      if (crises_a == 0) first_dt_a = $time - t_cf_a;
      else begin
        if ($time - t_f_a < lo_min) lo_min = $time - t_f_a;
        if ($time - t_f_a > lo_max) lo_max = $time - t_f_a;
      end
      sdiw_a = {sdiw_a[10:0], adc_sdi_a};
      rises_a++; crises_a++; t_r_a = $time;
    end
    if (sk_pa && !adc_sck_a) begin
      if ($time - t_r_a < hi_min) hi_min = $time - t_r_a;
      if ($time - t_r_a > hi_max) hi_max = $time - t_r_a;
      sh_a = {sh_a[10:0], 1'b0}; t_f_a = $time;
    end
    cv_pa = adc_convst_a; sk_pa = adc_sck_a;
  end

  logic [11:0] sh_b = '0;
  logic cv_pb = 1'b0, sk_pb = 1'b0;
  assign adc_sdo_b = sh_b[11];
  always @(adc_convst_b or adc_sck_b) begin
    if (cv_pb && !adc_convst_b) sh_b = ADC_B;
    if (sk_pb && !adc_sck_b) sh_b = {sh_b[10:0], 1'b0};
    cv_pb = adc_convst_b; sk_pb = adc_sck_b;
  end

  typedef struct { logic [11:0] v; time t; } exp_t;
  typedef struct { logic [11:0] val; logic en; logic pub; logic [11:0] exp; } vec_t;
  exp_t sb_a[$], sb_b[$];
  vec_t vec[6];
  int   checks = 0, errors = 0, r0 = 0;
  time  tT = 0;
  logic [2:0]  ch5 = 3'd5;
  logic [11:0] cfg_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input int which);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (((which == 0) ? (tmr_a != DIV_A - 1) : (tmr_b != DIV_B - 1)) && n < 3000);
    chk("tick_reached", n < 3000, 1);
    tT = $time - 1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_a && sample_valid_a) begin
        chk("strobe_a_pending", sb_a.size() > 0, 1);
        if (sb_a.size() > 0) begin
          e = sb_a.pop_front();
          chk("strobe_a_value", sample_a, e.v);
          chk("strobe_a_time", $time - 5, e.t);
        end
      end
      if (!reset_b && sample_valid_b) begin
        chk("strobe_b_pending", sb_b.size() > 0, 1);
        if (sb_b.size() > 0) begin
          e = sb_b.pop_front();
          chk("strobe_b_value", sample_b, e.v);
          chk("strobe_b_time", $time - 5, e.t);
        end
      end
    end
  endtask

  initial begin
`ifdef ADC_OVERSAMPLE_EN
    vec[0] = '{12'h123, 1'b1, 1'b0, 12'h000};
    vec[1] = '{12'd100, 1'b1, 1'b0, 12'h000};
    vec[2] = '{12'd101, 1'b1, 1'b0, 12'h000};
    vec[3] = '{12'd102, 1'b1, 1'b0, 12'h000};
    vec[4] = '{12'd103, 1'b1, 1'b1, 12'd101};
    vec[5] = '{12'h3C6, 1'b0, 1'b0, 12'h000};
`else
    vec[0] = '{12'h123, 1'b1, 1'b0, 12'h000};
    vec[1] = '{12'hA5C, 1'b1, 1'b1, 12'hA5C};
    vec[2] = '{12'h000, 1'b1, 1'b1, 12'h000};
    vec[3] = '{12'hFFF, 1'b1, 1'b1, 12'hFFF};
    vec[4] = '{12'h801, 1'b1, 1'b1, 12'h801};
    vec[5] = '{12'h3C6, 1'b0, 1'b0, 12'h000};
`endif
    cfg_a = {1'b1, ch5[0], ch5[2], ch5[1], 1'b1, 1'b0, 6'b0};
    fork monitor(); join_none

    enable_a = 1'b1; enable_b = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_convst", adc_convst_a, 0);
    chk("rst_sck", adc_sck_a, 0);
    chk("rst_sdi", adc_sdi_a, 0);
    chk("rst_sample", sample_a, 0);
    chk("rst_valid", sample_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_overrun", overrun_a, 0);
    chk("rst_busy_b", busy_b, 0);
    reset_a = 1'b0;

    for (int i = 0; i < 6; i++) begin
      adc_val_a = vec[i].val; enable_a = vec[i].en; r0 = rises_a;
      wait_tick(0);
      if (vec[i].pub) sb_a.push_back('{vec[i].exp, tT + LAT * TP});
      repeat (LAT + 9) @(posedge clk); #1;
      chk("busy_after_conv", busy_a, 0);
      chk("sck_rises", rises_a - r0, vec[i].en ? 12 : 0);
      if (vec[i].en) begin
        chk("sdi_word", sdiw_a, cfg_a);
        chk("sck_first_rise", first_dt_a, (CONV + 2) * TP);
      end
      if (vec[i].pub) chk("sample_held", sample_a, vec[i].exp);
    end
    chk("sck_hi_min", hi_min, CDIV * TP);
    chk("sck_hi_max", hi_max, CDIV * TP);
    chk("sck_lo_min", lo_min, CDIV * TP);
    chk("sck_lo_max", lo_max, CDIV * TP);
    chk("overrun_a", overrun_a, 0);

`ifndef ADC_OVERSAMPLE_EN
    // enable dropped mid-conversion: result still published, nothing further starts
    adc_val_a = 12'h5A5; enable_a = 1'b1;
    wait_tick(0);
    sb_a.push_back('{12'h5A5, tT + LAT * TP});
    repeat (10) @(posedge clk); #1;
    enable_a = 1'b0;
    wait_tick(0);
    r0 = rises_a;
    @(posedge clk); #1;
    chk("drop_busy", busy_a, 0);
    chk("drop_convst", adc_convst_a, 0);
    repeat (LAT + 9) @(posedge clk); #1;
    chk("drop_rises", rises_a - r0, 0);
    chk("drop_overrun", overrun_a, 0);
    chk("drop_sample", sample_a, 12'h5A5);

    // reset in the middle of SHIFT aborts, and re-arms suppression
    adc_val_a = 12'h111; enable_a = 1'b1;
    wait_tick(0);
    repeat (100) @(posedge clk); #1;
    chk("mid_shift_busy", busy_a, 1);
    reset_a = 1'b1;
    @(posedge clk); #1;
    chk("abort_sck", adc_sck_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_sample", sample_a, 0);
    reset_a = 1'b0;
    adc_val_a = 12'h777;
    wait_tick(0);
    repeat (LAT + 9) @(posedge clk); #1;
    chk("post_rst_suppressed", sample_a, 0);
    adc_val_a = 12'h2B4;
    wait_tick(0);
    sb_a.push_back('{12'h2B4, tT + LAT * TP});
    repeat (LAT + 9) @(posedge clk); #1;
    chk("post_rst_sample", sample_a, 12'h2B4);
`endif

    // SAMPLE_DIV=100: conversions outlast the tick period, so alternate ticks overrun
    reset_b = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wait_tick(1);
      if (k == 1) begin
        chk("ovr_b_before", overrun_b, 0);
        chk("busy_b_tick1", busy_b, 1);
        @(posedge clk); #1;
        chk("ovr_b_after", overrun_b, 1);
      end
`ifndef ADC_OVERSAMPLE_EN
      if (k == 2 || k == 4 || k == 6) sb_b.push_back('{ADC_B, tT + LAT * TP});
`endif
      if (k == 7) enable_b = 1'b0;
    end
    repeat (40) @(posedge clk); #1;
    chk("ovr_b_sticky", overrun_b, 1);
    chk("busy_b_end", busy_b, 0);

    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
